// File: rtl/mode_counter_ctrl.sv
// mode_counter_ctrl: sequences the mode counter register. It reloads the
// initial counter value, advances the counter through the 56-bit LFSR held
// in bits [63:8], and forwards cipher-core updates of the counter.
//
// Handshake: step_req is a level request held by the requester until
// step_ack. A request is accepted in IDLE on any clock edge where init and
// core_done are both low. step_ack is a one-cycle pulse that coincides with
// the cnt_crct strobe which writes the advanced value. step2 is sampled only
// on the accepting edge.
module mode_counter_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        init,
    input  logic        step_req,
    input  logic        step2,
    input  logic        core_done,
    input  logic [63:0] cnt_in,
    output logic        step_ack,
    output logic        cnt_en,
    output logic        cnt_crct,
    output logic [63:0] data_mode,
    output logic        busy,
    output logic        wrap,
    output logic [2:0]  state_dbg
);

    localparam logic [63:0] INIT_VAL = 64'h0100000000000000;
    localparam logic [55:0] INIT_S   = 56'h01000000000000;
    localparam logic [55:0] TAPS     = 56'h00000000000095;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_STEP  = 3'd3,
        ST_APPLY = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [63:0] shadow_q, shadow_d;
    logic        step2_q, step2_d;
    logic        step_cnt_q, step_cnt_d;
    logic        pending_q, pending_d;
    logic        wrap_q, wrap_d;
    logic        cnt_en_q, cnt_en_d;
    logic        cnt_crct_q, cnt_crct_d;
    logic        step_ack_q, step_ack_d;
    logic [55:0] s_next;

    // Galois form: shift left, fold the bit shifted out back in through the taps.
    function automatic logic [55:0] lfsr_next(input logic [55:0] s);
        lfsr_next = {s[54:0], 1'b0} ^ (s[55] ? TAPS : 56'h0);
    endfunction

    // State and all strobes are registered; outputs never see inputs combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            shadow_q   <= INIT_VAL;
            step2_q    <= 1'b0;
            step_cnt_q <= 1'b0;
            pending_q  <= 1'b0;
            wrap_q     <= 1'b0;
            cnt_en_q   <= 1'b0;
            cnt_crct_q <= 1'b0;
            step_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            step2_q    <= step2_d;
            step_cnt_q <= step_cnt_d;
            pending_q  <= pending_d;
            wrap_q     <= wrap_d;
            cnt_en_q   <= cnt_en_d;
            cnt_crct_q <= cnt_crct_d;
            step_ack_q <= step_ack_d;
        end
    end

    // Next-state, shadow/LFSR update and next strobe values.
    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        step2_d    = step2_q;
        step_cnt_d = step_cnt_q;
        pending_d  = pending_q;
        wrap_d     = wrap_q;
        cnt_en_d   = 1'b0;
        s_next     = lfsr_next(shadow_q[63:8]);

        case (state_q)
            ST_IDLE: begin
                if (init) begin
                    // A core update arriving with init is deferred until after the crct strobe.
                    state_d   = ST_INIT;
                    wrap_d    = 1'b0;
                    pending_d = core_done;
                end else if (core_done) begin
                    // Core value wins: the request stays pending and is taken
                    // once the counter register holds the core's value.
                    cnt_en_d = 1'b1;
                end else if (step_req) begin
                    state_d = ST_LOAD;
                    step2_d = step2;
                end
            end
            ST_INIT, ST_APPLY: begin
                // Deferred or coincident core updates land in the cycle after crct,
                // and any number of them collapse into one cnt_en.
                state_d   = ST_IDLE;
                cnt_en_d  = pending_q | core_done;
                pending_d = 1'b0;
            end
            ST_LOAD: begin
                if (core_done) begin
                    state_d  = ST_IDLE;
                    cnt_en_d = 1'b1;
                end else begin
                    shadow_d   = cnt_in;
                    step_cnt_d = 1'b0;
                    state_d    = ST_STEP;
                end
            end
            ST_STEP: begin
                if (core_done) begin
                    state_d  = ST_IDLE;
                    cnt_en_d = 1'b1;
                end else begin
                    shadow_d = {s_next, shadow_q[7:0]};
                    if (step2_q && !step_cnt_q) begin
                        step_cnt_d = 1'b1;
                    end else begin
                        state_d = ST_APPLY;
                        if (s_next == INIT_S) begin
                            wrap_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        cnt_crct_d = (state_d == ST_INIT) || (state_d == ST_APPLY);
        step_ack_d = (state_d == ST_APPLY);
    end

    assign cnt_en    = cnt_en_q;
    assign cnt_crct  = cnt_crct_q;
    assign step_ack  = step_ack_q;
    assign wrap      = wrap_q;
    assign busy      = (state_q != ST_IDLE);
    assign data_mode = (state_q == ST_INIT) ? INIT_VAL : shadow_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_mode_counter_ctrl.sv
// Directed bench for mode_counter_ctrl: init reload, LFSR stepping,
// core_done interaction in every state, wrap flag and reset behaviour.
module tb_mode_counter_ctrl;

    localparam logic [63:0] INIT_VAL = 64'h0100000000000000;

    logic        clk;
    logic        rst_n;
    logic        init;
    logic        step_req;
    logic        step2;
    logic        core_done;
    logic [63:0] cnt_in;
    logic        step_ack;
    logic        cnt_en;
    logic        cnt_crct;
    logic [63:0] data_mode;
    logic        busy;
    logic        wrap;
    logic [2:0]  state_dbg;

    int n_tests = 0;
    int n_fail  = 0;

    mode_counter_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init      (init),
        .step_req  (step_req),
        .step2     (step2),
        .core_done (core_done),
        .cnt_in    (cnt_in),
        .step_ack  (step_ack),
        .cnt_en    (cnt_en),
        .cnt_crct  (cnt_crct),
        .data_mode (data_mode),
        .busy      (busy),
        .wrap      (wrap),
        .state_dbg (state_dbg)
    );

    // Clock and watchdog.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // cnt_en and cnt_crct must never be high together.
    always @(negedge clk) begin
        chk("en_crct_excl", {63'b0, cnt_en & cnt_crct}, 64'h0);
    end

    // Issue one step request and check the ack cycle and result.
    task automatic run_step(input logic [63:0] cv, input logic s2, input logic [63:0] exp_d,
                            input int exp_lat, input logic exp_wrap);
        int  n;
        bit  seen;
        cnt_in   = cv;
        step2    = s2;
        step_req = 1'b1;
        n        = 0;
        seen     = 1'b0;
        while (!seen && n < 10) begin
            tick();
            n++;
            if (step_ack) seen = 1'b1;
        end
        step_req = 1'b0;
        step2    = 1'b0;
        chk("ack_seen", {63'b0, seen}, 64'h1);
        chk("ack_latency", n, exp_lat);
        chk("step_data", data_mode, exp_d);
        chk("crct_with_ack", {63'b0, cnt_crct}, 64'h1);
        chk("en_with_ack", {63'b0, cnt_en}, 64'h0);
        chk("wrap_at_apply", {63'b0, wrap}, {63'b0, exp_wrap});
        tick();
        chk("ack_one_cycle", {63'b0, step_ack}, 64'h0);
        chk("idle_after_step", {63'b0, busy}, 64'h0);
    endtask

    task automatic do_init();
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("init_crct", {63'b0, cnt_crct}, 64'h1);
        chk("init_data", data_mode, INIT_VAL);
        chk("init_wrap", {63'b0, wrap}, 64'h0);
        chk("init_busy", {63'b0, busy}, 64'h1);
        tick();
        chk("init_crct_end", {63'b0, cnt_crct}, 64'h0);
        chk("init_idle", {63'b0, busy}, 64'h0);
    endtask

    initial begin
        int n;
        bit seen;
        rst_n     = 1'b0;
        init      = 1'b0;
        step_req  = 1'b0;
        step2     = 1'b0;
        core_done = 1'b0;
        cnt_in    = 64'h0;
        tick();
        tick();
        chk("rst_cnt_en", {63'b0, cnt_en}, 64'h0);
        chk("rst_crct", {63'b0, cnt_crct}, 64'h0);
        chk("rst_ack", {63'b0, step_ack}, 64'h0);
        chk("rst_busy", {63'b0, busy}, 64'h0);
        chk("rst_wrap", {63'b0, wrap}, 64'h0);
        chk("rst_data", data_mode, INIT_VAL);
        rst_n = 1'b1;
        tick();

        do_init();

        // Plain stepping vectors.
        run_step(64'h0100000000000000, 1'b0, 64'h0200000000000000, 3, 1'b0);
        run_step(64'h0100000000000000, 1'b1, 64'h0400000000000000, 4, 1'b0);
        run_step(64'h80000000000000AB, 1'b0, 64'h00000000000095AB, 3, 1'b0);
        run_step(64'h80000000000000AB, 1'b1, 64'h0000000000012AAB, 4, 1'b0);
        run_step(64'hC000000000000012, 1'b1, 64'h000000000001BF12, 4, 1'b0);

        // Wrap: predecessor of the initial state, then stickiness, then clear.
        run_step(64'h00800000000000CD, 1'b0, 64'h01000000000000CD, 3, 1'b1);
        run_step(64'h0100000000000000, 1'b0, 64'h0200000000000000, 3, 1'b1);
        do_init();
        run_step(64'h0040000000000011, 1'b1, 64'h0100000000000011, 4, 1'b1);

        // core_done in IDLE.
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("idle_core_en", {63'b0, cnt_en}, 64'h1);
        chk("idle_core_busy", {63'b0, busy}, 64'h0);
        tick();
        chk("idle_core_en_end", {63'b0, cnt_en}, 64'h0);

        // core_done with init and again in INIT: one cnt_en after the crct.
        init      = 1'b1;
        core_done = 1'b1;
        tick();
        init = 1'b0;
        chk("init_core_crct", {63'b0, cnt_crct}, 64'h1);
        chk("init_core_no_en", {63'b0, cnt_en}, 64'h0);
        chk("init_core_wrap", {63'b0, wrap}, 64'h0);
        tick();
        core_done = 1'b0;
        chk("init_core_en", {63'b0, cnt_en}, 64'h1);
        chk("init_core_crct_end", {63'b0, cnt_crct}, 64'h0);
        tick();
        chk("init_core_collapse", {63'b0, cnt_en}, 64'h0);

        // core_done in APPLY.
        cnt_in   = 64'h0100000000000000;
        step2    = 1'b0;
        step_req = 1'b1;
        tick();
        tick();
        tick();
        chk("apply_core_ack", {63'b0, step_ack}, 64'h1);
        chk("apply_core_crct", {63'b0, cnt_crct}, 64'h1);
        core_done = 1'b1;
        step_req  = 1'b0;
        tick();
        core_done = 1'b0;
        chk("apply_core_en", {63'b0, cnt_en}, 64'h1);
        chk("apply_core_crct_end", {63'b0, cnt_crct}, 64'h0);
        tick();
        chk("apply_core_en_end", {63'b0, cnt_en}, 64'h0);

        // core_done in STEP: abort, cnt_en, re-accept from the new counter.
        cnt_in   = 64'h0100000000000000;
        step2    = 1'b1;
        step_req = 1'b1;
        tick();
        tick();
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("abort_no_ack", {63'b0, step_ack}, 64'h0);
        chk("abort_no_crct", {63'b0, cnt_crct}, 64'h0);
        chk("abort_en", {63'b0, cnt_en}, 64'h1);
        chk("abort_idle", {63'b0, busy}, 64'h0);
        cnt_in = 64'h80000000000000AB;
        n      = 0;
        seen   = 1'b0;
        while (!seen && n < 10) begin
            tick();
            n++;
            if (step_ack) seen = 1'b1;
        end
        step_req = 1'b0;
        step2    = 1'b0;
        chk("reaccept_seen", {63'b0, seen}, 64'h1);
        chk("reaccept_latency", n, 4);
        chk("reaccept_data", data_mode, 64'h0000000000012AAB);
        tick();

        // init while busy is ignored.
        cnt_in   = 64'h0100000000000000;
        step2    = 1'b1;
        step_req = 1'b1;
        tick();
        init = 1'b1;
        tick();
        tick();
        init = 1'b0;
        tick();
        chk("busy_init_ack", {63'b0, step_ack}, 64'h1);
        chk("busy_init_data", data_mode, 64'h0400000000000000);
        step_req = 1'b0;
        step2    = 1'b0;
        tick();
        chk("busy_init_no_crct", {63'b0, cnt_crct}, 64'h0);
        chk("busy_init_idle", {63'b0, busy}, 64'h0);

        // Reset in STEP with wrap set.
        run_step(64'h00800000000000CD, 1'b0, 64'h01000000000000CD, 3, 1'b1);
        cnt_in   = 64'h0100000000000000;
        step2    = 1'b1;
        step_req = 1'b1;
        tick();
        tick();
        chk("pre_rst_busy", {63'b0, busy}, 64'h1);
        rst_n = 1'b0;
        #1;
        step_req = 1'b0;
        step2    = 1'b0;
        chk("mid_rst_busy", {63'b0, busy}, 64'h0);
        chk("mid_rst_wrap", {63'b0, wrap}, 64'h0);
        chk("mid_rst_strobes", {61'b0, cnt_en, cnt_crct, step_ack}, 64'h0);
        chk("mid_rst_data", data_mode, INIT_VAL);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_rst_quiet", {60'b0, busy, cnt_en, cnt_crct, step_ack}, 64'h0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
